// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_arb_pkg;

  typedef enum logic {
    IDLE       = 1'b0,
    EXT_LOCKED = 1'b1
  } arb_state_e;

  localparam int REQ_CPU = 0;
  localparam int REQ_EXT = 1;
  localparam int WE_W    = 4;
  localparam int DATA_W  = 32;

endpackage

// File: rtl/dmem_arb_wait_ctr.sv
// Saturating up-counter with clear and a saturation flag; used for the ext
// starvation guard and for the optional performance counters.
module dmem_arb_wait_ctr #(
  parameter int CNT_W = 8,
  parameter int MAX   = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX);

  assign sat = (cnt == MAX_V);

  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (inc && !sat)
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbitrates BRAM port B between the MEM stage (cpu) and an external master
// (ext). Optional perf counters are enabled with `define DMEM_ARB_PERF_EN.
module dmem_port_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic [WE_W-1:0]   cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  input  logic              ext_req,
  input  logic              ext_lock,
  input  logic [WE_W-1:0]   ext_we,
  input  logic [31:0]       ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [WE_W-1:0]   web,
  output logic [31:0]       addrb,
  output logic [DATA_W-1:0] dib,
  input  logic [DATA_W-1:0] dob
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [CNT_W-1:0]  perf_conflicts,
  output logic [CNT_W-1:0]  perf_starve
`endif
);

  arb_state_e       state, state_nxt;
  logic             wait_sat;
  logic [CNT_W-1:0] unused_wait_cnt;
  logic             owner;

  dmem_arb_wait_ctr #(.CNT_W(CNT_W), .MAX(MAX_WAIT)) u_wait_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (ext_req & ~ext_gnt),
    .clr   (ext_gnt | ~ext_req),
    .cnt   (unused_wait_cnt),
    .sat   (wait_sat)
  );

  // Grants are combinational; holding rst_n low suppresses every grant so no
  // write can reach the BRAM during reset.
  always_comb begin
    cpu_gnt   = 1'b0;
    ext_gnt   = 1'b0;
    state_nxt = state;
    if (rst_n) begin
      case (state)
        IDLE: begin
          if (ext_req && (!cpu_req || wait_sat))
            ext_gnt = 1'b1;
          else
            cpu_gnt = cpu_req;
          if (ext_gnt && ext_lock)
            state_nxt = EXT_LOCKED;
        end
        EXT_LOCKED: begin
          ext_gnt = ext_req;
          if (!ext_lock)
            state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;
  assign owner     = ext_gnt ? 1'(REQ_EXT) : 1'(REQ_CPU);

  always_comb begin
    web   = '0;
    addrb = cpu_addr;
    dib   = cpu_wdata;
    if (owner == 1'(REQ_EXT)) begin
      web   = ext_we;
      addrb = ext_addr;
      dib   = ext_wdata;
    end else if (cpu_gnt) begin
      web   = cpu_we;
    end
  end

  // BRAM read data lands one cycle after the grant
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_rvalid <= 1'b0;
      ext_rvalid <= 1'b0;
    end else begin
      cpu_rvalid <= cpu_gnt && (cpu_we == '0);
      ext_rvalid <= ext_gnt && (ext_we == '0);
    end
  end

  assign rdata = dob;

`ifdef DMEM_ARB_PERF_EN
  localparam int PERF_MAX = (1 << CNT_W) - 1;

  logic starve_hit;
  logic unused_conf_sat, unused_starve_sat;

  assign starve_hit = ext_gnt & cpu_req & (state == IDLE);

  dmem_arb_wait_ctr #(.CNT_W(CNT_W), .MAX(PERF_MAX)) u_perf_conf (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cpu_req & ext_req),
    .clr   (1'b0),
    .cnt   (perf_conflicts),
    .sat   (unused_conf_sat)
  );

  dmem_arb_wait_ctr #(.CNT_W(CNT_W), .MAX(PERF_MAX)) u_perf_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (starve_hit),
    .clr   (1'b0),
    .cnt   (perf_starve),
    .sat   (unused_starve_sat)
  );
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios followed by a
// randomized phase, all checked against a behavioural model and shadow memory.
module tb_dmem_port_arbiter;

  localparam int MAX_WAIT = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, ext_req, ext_lock;
  logic [3:0]  cpu_we, ext_we;
  logic [31:0] cpu_addr, cpu_wdata, ext_addr, ext_wdata;
  logic        cpu_gnt, cpu_stall, cpu_rvalid, ext_gnt, ext_rvalid;
  logic [31:0] rdata, addrb, dib, dob;
  logic [3:0]  web;

  int checks   = 0;
  int failures = 0;

  dmem_port_arbiter #(.MAX_WAIT(MAX_WAIT), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_gnt    (cpu_gnt),
    .cpu_stall  (cpu_stall),
    .cpu_rvalid (cpu_rvalid),
    .ext_req    (ext_req),
    .ext_lock   (ext_lock),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .rdata      (rdata),
    .web        (web),
    .addrb      (addrb),
    .dib        (dib),
    .dob        (dob)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(int i);
    return (i == 16) ? 32'hDEADBEEF : (32'hA500_0000 ^ 32'(i * 32'h0001_0203));
  endfunction

  // BRAM model: 1-cycle synchronous read, byte-enabled write
  logic [31:0] mem [0:255];
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_init <= 1'b1;
    end else begin
      for (int b = 0; b < 4; b++)
        if (web[b]) mem[addrb[9:2]][8*b +: 8] <= dib[8*b +: 8];
    end
    dob <= mem[addrb[9:2]];
  end

  // Reference model state
  logic [31:0] shadow [0:255];
  bit          m_locked;
  int          m_wait;
  bit          m_cpu_rv, m_ext_rv;
  logic [31:0] m_rdata;

  // Values sampled in the most recent cycle
  logic        s_cpu_gnt, s_ext_gnt, s_cpu_stall, s_cpu_rv, s_ext_rv;
  logic [3:0]  s_web;
  logic [31:0] s_rdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr_shadow(input logic [31:0] a, input logic [31:0] w, input logic [3:0] we);
    for (int b = 0; b < 4; b++)
      if (we[b]) shadow[a[9:2]][8*b +: 8] = w[8*b +: 8];
  endtask

  task automatic tick();
    bit         eg, cg;
    logic [3:0] ew;
    @(negedge clk);
    if (!rst_n) begin
      eg = 1'b0; cg = 1'b0;
    end else if (m_locked) begin
      eg = ext_req; cg = 1'b0;
    end else begin
      eg = ext_req && (!cpu_req || m_wait >= MAX_WAIT);
      cg = cpu_req && !eg;
    end
    ew = eg ? ext_we : (cg ? cpu_we : 4'h0);
    s_cpu_gnt = cpu_gnt; s_ext_gnt = ext_gnt; s_cpu_stall = cpu_stall;
    s_cpu_rv = cpu_rvalid; s_ext_rv = ext_rvalid; s_web = web; s_rdata = rdata;
    chk("cpu_gnt", 32'(cpu_gnt), 32'(cg));
    chk("ext_gnt", 32'(ext_gnt), 32'(eg));
    chk("cpu_stall", 32'(cpu_stall), 32'(cpu_req && !cg));
    chk("web", 32'(web), 32'(ew));
    if (rst_n) chk("addrb", addrb, eg ? ext_addr : cpu_addr);
    if (eg) chk("dib_ext", dib, ext_wdata);
    if (cg) chk("dib_cpu", dib, cpu_wdata);
    chk("cpu_rvalid", 32'(cpu_rvalid), 32'(m_cpu_rv));
    chk("ext_rvalid", 32'(ext_rvalid), 32'(m_ext_rv));
    if (m_cpu_rv || m_ext_rv) chk("rdata", rdata, m_rdata);
    @(posedge clk);
    if (!rst_n) begin
      m_locked = 1'b0; m_wait = 0; m_cpu_rv = 1'b0; m_ext_rv = 1'b0;
    end else begin
      m_cpu_rv = cg && (cpu_we == 4'h0);
      m_ext_rv = eg && (ext_we == 4'h0);
      if (m_cpu_rv) m_rdata = shadow[cpu_addr[9:2]];
      if (m_ext_rv) m_rdata = shadow[ext_addr[9:2]];
      if (cg) wr_shadow(cpu_addr, cpu_wdata, cpu_we);
      if (eg) wr_shadow(ext_addr, ext_wdata, ext_we);
      if (ext_req && !eg) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : MAX_WAIT;
      else m_wait = 0;
      m_locked = m_locked ? ext_lock : (eg && ext_lock);
    end
    #1;
  endtask

  task automatic rand_cpu();
    cpu_req   = 1'($urandom_range(0, 1));
    cpu_we    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
    cpu_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
    cpu_wdata = $urandom;
  endtask

  task automatic rand_ext();
    ext_req   = 1'($urandom_range(0, 1));
    ext_we    = $urandom_range(0, 1) ? 4'h0 : 4'($urandom_range(1, 15));
    ext_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
    ext_wdata = $urandom;
  endtask

  initial begin
    int ncpu;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    m_locked = 1'b0; m_wait = 0; m_cpu_rv = 1'b0; m_ext_rv = 1'b0; m_rdata = '0;
    rst_n = 1'b0;
    cpu_req = 1'b0; cpu_we = 4'h0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_lock = 1'b0; ext_we = 4'h0; ext_addr = '0; ext_wdata = '0;
    tick();
    tick();

    // Reset release with no requests
    rst_n = 1'b1;
    tick();
    chk("idle_cpu_gnt", 32'(s_cpu_gnt), 32'd0);
    chk("idle_ext_gnt", 32'(s_ext_gnt), 32'd0);
    chk("idle_web", 32'(s_web), 32'd0);
    chk("idle_rvalid", 32'({s_cpu_rv, s_ext_rv}), 32'd0);

    // cpu-only read of 0x40
    cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h40;
    tick();
    chk("rd_gnt", 32'(s_cpu_gnt), 32'd1);
    cpu_req = 1'b0;
    tick();
    chk("rd_rvalid", 32'(s_cpu_rv), 32'd1);
    chk("rd_data", s_rdata, 32'hDEADBEEF);

    // Continuous contention: 8 cpu grants then a forced ext grant
    cpu_req = 1'b1; cpu_addr = 32'h80;
    ext_req = 1'b1; ext_we = 4'h0; ext_addr = 32'h44;
    ncpu = 0;
    for (int i = 0; i < 18; i++) begin
      tick();
      if (s_cpu_gnt) ncpu++;
      if (i == 8 || i == 17) begin
        chk("force_ext_gnt", 32'(s_ext_gnt), 32'd1);
        chk("force_stall", 32'(s_cpu_stall), 32'd1);
      end
    end
    chk("contention_cpu_grants", 32'(ncpu), 32'd16);
    cpu_req = 1'b0; ext_req = 1'b0;
    tick();

    // ext locked write burst while cpu waits
    ext_req = 1'b1; ext_lock = 1'b1; ext_we = 4'hF;
    ext_addr = 32'h100; ext_wdata = 32'h1122_3344;
    tick();
    chk("lock_first_gnt", 32'(s_ext_gnt), 32'd1);
    chk("lock_first_web", 32'(s_web), 32'hF);
    cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h100;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("lock_cpu_blocked", 32'(s_cpu_gnt), 32'd0);
      chk("lock_ext_gnt", 32'(s_ext_gnt), 32'd1);
    end
    ext_req = 1'b0; ext_lock = 1'b0;
    tick();
    chk("unlock_edge_cpu_blocked", 32'(s_cpu_gnt), 32'd0);
    tick();
    chk("after_unlock_cpu_gnt", 32'(s_cpu_gnt), 32'd1);
    cpu_req = 1'b0;
    tick();
    chk("lock_readback", s_rdata, 32'h1122_3344);

    // Byte store then read back
    cpu_req = 1'b1; cpu_we = 4'b0010; cpu_wdata = 32'h0000_AB00; cpu_addr = 32'h200;
    tick();
    chk("byte_web", 32'(s_web), 32'h2);
    cpu_we = 4'h0;
    tick();
    chk("byte_no_rvalid", 32'(s_cpu_rv), 32'd0);
    cpu_req = 1'b0;
    tick();
    chk("byte_rvalid", 32'(s_cpu_rv), 32'd1);
    chk("byte_readback", 32'(s_rdata[15:8]), 32'hAB);

    // Reset while ext holds the lock with a read in flight
    ext_req = 1'b1; ext_lock = 1'b1; ext_we = 4'h0; ext_addr = 32'h100;
    tick();
    chk("rst_pre_ext_gnt", 32'(s_ext_gnt), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("rst_gnt_forced", 32'(s_ext_gnt), 32'd0);
    chk("rst_web_forced", 32'(s_web), 32'd0);
    rst_n = 1'b1; ext_req = 1'b0; ext_lock = 1'b0;
    cpu_req = 1'b1; cpu_we = 4'h0; cpu_addr = 32'h40;
    tick();
    chk("rst_rvalid_dropped", 32'(s_ext_rv), 32'd0);
    chk("rst_cpu_gnt", 32'(s_cpu_gnt), 32'd1);

    // Randomized traffic, requesters hold their request until granted
    rand_cpu();
    rand_ext();
    for (int i = 0; i < 400; i++) begin
      ext_lock = ($urandom_range(0, 3) == 0);
      rst_n    = ($urandom_range(0, 59) != 0);
      tick();
      if (!(cpu_req && !s_cpu_gnt)) rand_cpu();
      if (!(ext_req && !s_ext_gnt)) rand_ext();
    end
    rst_n = 1'b1; cpu_req = 1'b0; ext_req = 1'b0; ext_lock = 1'b0;
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
